load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory request protocol. It sits between the pipeline MEM stage and the data memory port. It accepts one load/store operation at a time and decodes RISC-V funct3 into width/sign controls. It checks alignment, drives the single-cycle memory request, captures the registered read data, and returns a response with an optional circular post-increment pointer for DSP loops. It stalls the pipeline while an access is in flight and retries when the memory is not ready.

## Interface
- `MAX_RETRY`, default 3: number of re-issues allowed when `mem_ready`=0 before an error response.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: operation offered by the MEM stage.
- `req_ready` output 1: LSU can accept; high only in IDLE.
- `req_is_store` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned.
- `req_circ` input 1: request circular post-increment.
- `req_step` input 32: post-increment step in bytes.
- `circ_base` input 32: circular buffer base address.
- `circ_size` input 32: circular buffer size in bytes.
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output 32: load result; 0 for stores and errors.
- `resp_next_ptr` output 32: post-incremented pointer.
- `resp_err` output 1: misaligned access, illegal funct3, or retry exhaustion.
- `busy` output 1: pipeline stall; high from accept through the `resp_valid` cycle.
- `mem_addr` output 32: request address.
- `mem_write_data` output 32: store data.
- `mem_read` output 1: read request.
- `mem_write` output 1: write request.
- `mem_width` output 3: {1'b0, funct3[1:0]}.
- `mem_signed` output 1: ~funct3[2].
- `mem_read_data` input 32: responder's registered read data.
- `mem_ready` input 1: responder ready.

## Operation
- FSM states are IDLE, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch all request fields.
  - If the access is illegal, go to RESP with `resp_err`=1 and issue no memory request.
    - Illegal funct3: load 011/110/111; store with funct3[2]=1 or funct3=011.
    - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise go to REQ.
- REQ:
  - `mem_read` (load) or `mem_write` (store) is high for exactly this cycle.
  - `mem_addr`, `mem_width`, `mem_signed` and `mem_write_data` are driven from the latched fields.
  - Always go to WAIT.
- WAIT:
  - Requests are deasserted.
  - If `mem_ready`=1: capture `mem_read_data` (loads only; 0 for stores) and go to RESP.
  - If `mem_ready`=0 and retries < `MAX_RETRY`: increment the retry counter and go back to REQ (re-issue).
  - Otherwise set the error and go to RESP.
- RESP:
  - `resp_valid`=1 for one cycle; then go to IDLE and clear the retry counter.
- Post-increment pointer:
  - Compute p = addr + step using 32-bit wrapping addition.
  - If `req_circ`=1 and p ≥ base+size, then `resp_next_ptr` = p − size.
  - If `req_circ`=0, `resp_next_ptr` = p.
  - `circ_size`=0 with `req_circ`=1 is treated as non-circular.
  - The pointer is valid even when `resp_err`=1.
- Store data is passed unshifted; the responder does byte-lane placement.
- Load data is passed through as returned by the responder, which has already applied sign/zero extension.

## Timing
- Reset values (asynchronous): state IDLE, all outputs 0 except `req_ready`=1; retry counter 0; latched fields 0.
- Legal access with `mem_ready`=1:
  - Accept at edge E0.
  - REQ in cycle 1.
  - WAIT in cycle 2; `mem_read_data` is sampled at the edge ending cycle 2.
  - `resp_valid` in cycle 3.
  - Total latency from accept edge to response is 3 cycles; `busy` covers cycles 1-3.
- Illegal access: `resp_valid` in cycle 1, and no `mem_read`/`mem_write` pulse.
- Each retry adds 2 cycles. Worst case is 3 + 2·`MAX_RETRY` cycles.
- `mem_read` and `mem_write` are never both high, and are never high outside REQ.
- A new request is not accepted in the RESP cycle; back-to-back throughput is one access per 4 cycles.
- Reset asserted mid-access aborts immediately: no response is produced and the memory request is dropped.

## Structure
- A shared package holds:
  - FSM state enum.
  - funct3 localparams (`F3_B`/`F3_H`/`F3_W`/`F3_BU`/`F3_HU`).
  - The `MEM_W_8`/`MEM_W_16`/`MEM_W_32` width codes shared with the data memory responder.
- One natural sub-module: `circ_ptr_update` (combinational post-increment and wrap).

## Test plan
- LW at addr 0x10 after memory word 0x10 = 0xDEADBEEF → single `mem_read` pulse, `mem_width`=010, `resp_valid` 3 cycles after accept with `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- SH addr 0x22, wdata 0x1234ABCD → `mem_write`=1 one cycle with `mem_width`=001, `mem_signed`=1; response `resp_rdata`=0, `resp_err`=0; a later LHU at 0x22 returns 0x0000ABCD.
- LW at addr 0x6 → `resp_valid` in cycle 1, `resp_err`=1, no `mem_read` pulse ever asserted.
- Load with `mem_ready` held 0 and `MAX_RETRY`=3 → exactly 4 `mem_read` pulses, then `resp_err`=1 at cycle 9.
- Circular load with addr 0x1FC, step 4, base 0x100, size 0x100 → `resp_next_ptr`=0x100; with step 4, addr 0x1F0 → 0x1F4.
- Reset pulsed during WAIT → all outputs 0 and `req_ready`=1 immediately; no `resp_valid`; the next LW completes normally in 3 cycles.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, RISC-V funct3
// encodings, data-memory width codes and the request legality helpers.
package load_store_unit_pkg;

    // LSU sequencing states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width codes understood by the data memory responder
    localparam logic [2:0] MEM_W_8  = 3'b000;
    localparam logic [2:0] MEM_W_16 = 3'b001;
    localparam logic [2:0] MEM_W_32 = 3'b010;

    // Fields held for the whole access so that retries re-issue the same request
    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] next_ptr;
    } lsu_req_t;

    // Unsigned sub-word variants only exist for loads; 011/11x are never legal.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] funct3);
        logic bad;
        case (funct3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = is_store;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Halfwords need even addresses, words need 4-byte aligned addresses.
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [2:0] width;
        logic       mis;
        width = {1'b0, funct3[1:0]};
        if (width == MEM_W_16) begin
            mis = addr_lo[0];
        end else if (width == MEM_W_32) begin
            mis = (addr_lo != 2'b00);
        end else begin
            mis = 1'b0;
        end
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_circ_ptr_update.sv
// Post-increment pointer with optional circular-buffer wrap, used by DSP
// loops that walk a ring buffer. Purely combinational.
module circ_ptr_update (
    input  logic [31:0] i_addr,
    input  logic [31:0] i_step,
    input  logic        i_circ,
    input  logic [31:0] i_base,
    input  logic [31:0] i_size,
    output logic [31:0] o_next_ptr
);

    logic [31:0] w_sum;
    logic [31:0] w_limit;
    logic        w_wrap_en;

    assign w_sum     = i_addr + i_step;
    assign w_limit   = i_base + i_size;
    // A zero-sized ring degenerates to a plain post-increment.
    assign w_wrap_en = i_circ && (i_size != 32'd0);

    // Fold the incremented pointer back by one buffer length when it runs past the end
    always_comb begin
        o_next_ptr = w_sum;
        if (w_wrap_en && (w_sum >= w_limit)) begin
            o_next_ptr = w_sum - i_size;
        end else begin
            o_next_ptr = w_sum;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory request protocol.
// Accepts one access at a time from the MEM stage, rejects illegal or
// misaligned accesses without touching memory, issues a single-cycle
// request, re-issues it while the responder is not ready (bounded by
// MAX_RETRY) and returns a one-cycle response with the post-increment pointer.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    // MEM stage request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_circ,
    input  logic [31:0] req_step,
    input  logic [31:0] circ_base,
    input  logic [31:0] circ_size,
    // MEM stage response
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] resp_next_ptr,
    output logic        resp_err,
    output logic        busy,
    // Data memory port
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_width,
    output logic        mem_signed,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    lsu_state_e         r_state;
    lsu_req_t           r_req;
    logic [RETRY_W-1:0] r_retry;

    logic               w_illegal;
    logic [31:0]        w_next_ptr;

    // The pointer is computed from the live request and captured at accept,
    // so it is available for both the error path and the normal path.
    circ_ptr_update u_circ_ptr_update (
        .i_addr     (req_addr),
        .i_step     (req_step),
        .i_circ     (req_circ),
        .i_base     (circ_base),
        .i_size     (circ_size),
        .o_next_ptr (w_next_ptr)
    );

    assign w_illegal = f3_illegal(req_is_store, req_funct3)
                     | addr_misaligned(req_funct3, req_addr[1:0]);

    // Request/response sequencer; every port output is a register of this block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_req          <= '0;
            r_retry        <= '0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_next_ptr  <= 32'd0;
            resp_err       <= 1'b0;
            mem_addr       <= 32'd0;
            mem_write_data <= 32'd0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_width      <= 3'd0;
            mem_signed     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req <= '{is_store: req_is_store,
                                   funct3:   req_funct3,
                                   addr:     req_addr,
                                   wdata:    req_wdata,
                                   next_ptr: w_next_ptr};
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (w_illegal) begin
                            // Reject straight away; memory never sees the access.
                            r_state       <= S_RESP;
                            resp_valid    <= 1'b1;
                            resp_err      <= 1'b1;
                            resp_rdata    <= 32'd0;
                            resp_next_ptr <= w_next_ptr;
                        end else begin
                            r_state        <= S_REQ;
                            mem_read       <= ~req_is_store;
                            mem_write      <= req_is_store;
                            mem_addr       <= req_addr;
                            mem_write_data <= req_is_store ? req_wdata : 32'd0;
                            mem_width      <= {1'b0, req_funct3[1:0]};
                            mem_signed     <= ~req_funct3[2];
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_REQ: begin
                    // The request was presented for exactly one cycle.
                    r_state        <= S_WAIT;
                    mem_addr       <= 32'd0;
                    mem_write_data <= 32'd0;
                    mem_width      <= 3'd0;
                    mem_signed     <= 1'b0;
                end

                S_WAIT: begin
                    if (mem_ready) begin
                        r_state       <= S_RESP;
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b0;
                        resp_rdata    <= r_req.is_store ? 32'd0 : mem_read_data;
                        resp_next_ptr <= r_req.next_ptr;
                    end else if (r_retry < RETRY_MAX) begin
                        // Responder busy: re-issue the identical request.
                        r_state        <= S_REQ;
                        r_retry        <= r_retry + {{(RETRY_W-1){1'b0}}, 1'b1};
                        mem_read       <= ~r_req.is_store;
                        mem_write      <= r_req.is_store;
                        mem_addr       <= r_req.addr;
                        mem_write_data <= r_req.is_store ? r_req.wdata : 32'd0;
                        mem_width      <= {1'b0, r_req.funct3[1:0]};
                        mem_signed     <= ~r_req.funct3[2];
                    end else begin
                        // Out of retries: report an error instead of stalling forever.
                        r_state       <= S_RESP;
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b1;
                        resp_rdata    <= 32'd0;
                        resp_next_ptr <= r_req.next_ptr;
                    end
                end

                S_RESP: begin
                    // Response cycle ends; only now may a new access be accepted.
                    r_state       <= S_IDLE;
                    r_retry       <= '0;
                    req_ready     <= 1'b1;
                    busy          <= 1'b0;
                    resp_err      <= 1'b0;
                    resp_rdata    <= 32'd0;
                    resp_next_ptr <= 32'd0;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_retry   <= '0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    resp_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-addressed responder model,
// a shadow memory reference, table-driven directed vectors, a reset-abort
// sequence and randomized accesses checked against the reference.
module tb_load_store_unit;

    localparam int MAX_RETRY = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_is_store, req_circ;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, req_step, circ_base, circ_size;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata, resp_next_ptr;
    logic [31:0] mem_addr, mem_write_data;
    logic        mem_read, mem_write, mem_signed;
    logic [2:0]  mem_width;
    logic [31:0] mem_read_data = 32'd0;
    logic        mem_ready     = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_circ(req_circ), .req_step(req_step), .circ_base(circ_base), .circ_size(circ_size),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_next_ptr(resp_next_ptr),
        .resp_err(resp_err), .busy(busy),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_width(mem_width), .mem_signed(mem_signed),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready)
    );

    // ---------------- responder (environment) ----------------
    logic [7:0]  dmem [0:255];
    int unsigned pulse_cnt   = 0;
    int unsigned ready_after = 0;

    function automatic logic [31:0] resp_word(input logic [7:0] a, input logic [2:0] w, input logic s);
        logic [31:0] v;
        v = {dmem[a + 8'd3], dmem[a + 8'd2], dmem[a + 8'd1], dmem[a]};
        case (w)
            3'd0:    v = s ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
            3'd1:    v = s ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
            default: v = v;
        endcase
        return v;
    endfunction

    // Registered-read responder; not ready for the first ready_after pulses of an access
    always @(posedge clk) begin
        if (mem_read || mem_write) begin
            pulse_cnt <= pulse_cnt + 1;
            mem_ready <= ((pulse_cnt + 1) > ready_after);
        end
        if (mem_write) begin
            dmem[mem_addr[7:0]] <= mem_write_data[7:0];
            if (mem_width != 3'd0) dmem[mem_addr[7:0] + 8'd1] <= mem_write_data[15:8];
            if (mem_width == 3'd2) begin
                dmem[mem_addr[7:0] + 8'd2] <= mem_write_data[23:16];
                dmem[mem_addr[7:0] + 8'd3] <= mem_write_data[31:24];
            end
        end
        if (mem_read) mem_read_data <= resp_word(mem_addr[7:0], mem_width, mem_signed);
    end

    // ---------------- reference model ----------------
    int unsigned ref_mem [256];

    function automatic int nbytes_of(input logic [2:0] f3);
        logic [1:0] sz;
        sz = f3[1:0];
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_illegal(input logic st, input logic [2:0] f3, input int unsigned a);
        bit bad_f3, mis;
        int n;
        n = nbytes_of(f3);
        if (st) bad_f3 = (f3 > 3'd2);
        else    bad_f3 = (f3 == 3'd3) || (f3 >= 3'd6);
        mis = (a % n) != 0;
        return bad_f3 || mis;
    endfunction

    function automatic int unsigned model_load(input int unsigned a, input logic [2:0] f3);
        int unsigned v;
        int n;
        n = nbytes_of(f3);
        v = 0;
        for (int i = 0; i < n; i++) v += ref_mem[(a + i) % 256] << (8 * i);
        if (!f3[2] && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    function automatic void model_store(input int unsigned a, input logic [2:0] f3, input int unsigned wd);
        int n;
        n = nbytes_of(f3);
        for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = (wd >> (8 * i)) & 32'hFF;
    endfunction

    function automatic int unsigned model_ptr(input int unsigned a, step, base, size, input logic circ);
        int unsigned p;
        p = a + step;
        if (circ && size != 0 && p >= base + size) p = p - size;
        return p;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic circ,
                          input logic [31:0] step, input logic [31:0] base, input logic [31:0] size,
                          input int nbusy, input logic e_err, input int e_lat,
                          input logic [31:0] e_rdata, input logic [31:0] e_ptr, input int e_pulses);
        int cyc;
        int pulses;
        bit fields_ok;
        bit seen;
        logic [1:0] st_at_resp;
        pulses = 0; fields_ok = 1'b1; seen = 1'b0; st_at_resp = 2'b00;
        @(negedge clk);
        check({nm, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_circ = circ; req_step = step; circ_base = base; circ_size = size;
        ready_after = pulse_cnt + nbusy;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (cyc <= 40) begin
            if (mem_read || mem_write) begin
                pulses++;
                if (mem_read && mem_write) fields_ok = 1'b0;
                if (mem_read != !st || mem_addr != a || mem_width != {1'b0, f3[1:0]} || mem_signed != !f3[2])
                    fields_ok = 1'b0;
                if (st && mem_write_data != wd) fields_ok = 1'b0;
            end
            if (!busy) fields_ok = 1'b0;
            if (resp_valid) begin
                seen = 1'b1;
                st_at_resp = {busy, req_ready};
                break;
            end
            cyc++;
            @(negedge clk);
        end
        check({nm, " resp seen"}, 32'(seen), 32'd1);
        check({nm, " latency"},   32'(cyc), 32'(e_lat));
        check({nm, " err"},       32'(resp_err), 32'(e_err));
        check({nm, " rdata"},     resp_rdata, e_rdata);
        check({nm, " next_ptr"},  resp_next_ptr, e_ptr);
        check({nm, " pulses"},    32'(pulses), 32'(e_pulses));
        check({nm, " req fields/busy"}, 32'(fields_ok), 32'd1);
        check({nm, " busy,ready@resp"}, 32'(st_at_resp), 32'd2);
        @(negedge clk);
        check({nm, " after resp"}, {29'd0, resp_valid, busy, req_ready}, 32'd1);
        if (st && !model_illegal(st, f3, a)) model_store(a, f3, wd);
    endtask

    typedef struct {
        logic st; logic [2:0] f3; logic [31:0] a; logic [31:0] wd;
        logic circ; logic [31:0] step; logic [31:0] base; logic [31:0] size; int nbusy;
        logic e_err; int e_lat; logic [31:0] e_rdata; logic [31:0] e_ptr; int e_pulses;
    } vec_t;

    vec_t tbl[$];

    initial begin
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
        req_wdata = 32'd0; req_circ = 1'b0; req_step = 32'd0; circ_base = 32'd0; circ_size = 32'd0;

        // Directed table: {st,f3,addr,wdata,circ,step,base,size,nbusy, err,lat,rdata,ptr,pulses}
        tbl.push_back('{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'h0,        32'h10,  1});
        tbl.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'd4, 32'd0, 32'd0, 0, 1'b0, 3, 32'hDEADBEEF, 32'h14,  1});
        tbl.push_back('{1'b1, 3'd1, 32'h22,  32'h1234ABCD, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'h0,        32'h22,  1});
        tbl.push_back('{1'b0, 3'd5, 32'h22,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'h0000ABCD, 32'h22,  1});
        tbl.push_back('{1'b0, 3'd1, 32'h22,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'hFFFFABCD, 32'h22,  1});
        tbl.push_back('{1'b0, 3'd0, 32'h13,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'hFFFFFFDE, 32'h13,  1});
        tbl.push_back('{1'b0, 3'd4, 32'h11,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'h000000BE, 32'h11,  1});
        tbl.push_back('{1'b0, 3'd2, 32'h6,   32'h0,        1'b0, 32'd2, 32'd0, 32'd0, 0, 1'b1, 1, 32'h0,        32'h8,   0});
        tbl.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 9, 1'b1, 9, 32'h0,        32'h10,  4});
        tbl.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 3, 1'b0, 9, 32'hDEADBEEF, 32'h10,  4});
        tbl.push_back('{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 1, 1'b0, 5, 32'hDEADBEEF, 32'h10,  2});
        tbl.push_back('{1'b1, 3'd2, 32'h1FC, 32'h0BADF00D, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'h0,        32'h1FC, 1});
        tbl.push_back('{1'b1, 3'd2, 32'h1F0, 32'hCAFE0001, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'h0,        32'h1F0, 1});
        tbl.push_back('{1'b0, 3'd2, 32'h1FC, 32'h0,        1'b1, 32'd4, 32'h100, 32'h100, 0, 1'b0, 3, 32'h0BADF00D, 32'h100, 1});
        tbl.push_back('{1'b0, 3'd2, 32'h1F0, 32'h0,        1'b1, 32'd4, 32'h100, 32'h100, 0, 1'b0, 3, 32'hCAFE0001, 32'h1F4, 1});
        tbl.push_back('{1'b0, 3'd2, 32'h1FC, 32'h0,        1'b1, 32'd4, 32'h100, 32'h0,   0, 1'b0, 3, 32'h0BADF00D, 32'h200, 1});
        tbl.push_back('{1'b1, 3'd4, 32'h30,  32'h55,       1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b1, 1, 32'h0,        32'h30,  0});
        tbl.push_back('{1'b0, 3'd3, 32'h30,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b1, 1, 32'h0,        32'h30,  0});
        tbl.push_back('{1'b1, 3'd1, 32'h21,  32'h66,       1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b1, 1, 32'h0,        32'h21,  0});
        tbl.push_back('{1'b0, 3'd6, 32'h30,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b1, 1, 32'h0,        32'h30,  0});
        tbl.push_back('{1'b1, 3'd0, 32'h23,  32'hFFFFFF77, 1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'h0,        32'h23,  1});
        tbl.push_back('{1'b0, 3'd1, 32'h22,  32'h0,        1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, 3, 32'h000077CD, 32'h22,  1});

        // Reset state
        repeat (2) @(negedge clk);
        check("reset ctl", {26'd0, req_ready, busy, resp_valid, resp_err, mem_read, mem_write}, 32'h20);
        check("reset data", resp_rdata | resp_next_ptr | mem_addr | mem_write_data, 32'd0);
        check("reset width", {28'd0, mem_width, mem_signed}, 32'd0);
        rst_n = 1'b1;

        // Preload every memory word so random loads have defined contents
        for (int i = 0; i < 64; i++) begin
            logic [31:0] wd_p;
            wd_p = $urandom;
            run_op("preload", 1'b1, 3'd2, 32'(4 * i), wd_p, 1'b0, 32'd0, 32'd0, 32'd0, 0,
                   1'b0, 3, 32'd0, 32'(4 * i), 1);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].circ,
                   tbl[i].step, tbl[i].base, tbl[i].size, tbl[i].nbusy,
                   tbl[i].e_err, tbl[i].e_lat, tbl[i].e_rdata, tbl[i].e_ptr, tbl[i].e_pulses);
        end

        // Reset during WAIT aborts the access without a response
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        req_circ = 1'b0; req_step = 32'd0; ready_after = pulse_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstseq REQ read", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstseq abort ctl", {26'd0, req_ready, busy, resp_valid, resp_err, mem_read, mem_write}, 32'h20);
        check("rstseq abort data", resp_rdata | resp_next_ptr | mem_addr, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rstseq no resp", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        run_op("post-reset LW", 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 0,
               1'b0, 3, 32'hDEADBEEF, 32'h10, 1);

        // Randomized accesses against the reference model
        for (int k = 0; k < 80; k++) begin
            logic        st, circ, ill, e_err;
            logic [2:0]  f3;
            logic [31:0] a, wd, step, base, size, e_rd, e_ptr;
            int          nb, tries, e_lat, e_pul;
            st   = 1'($urandom_range(0, 1));
            f3   = (($urandom_range(0, 4)) == 0) ? 3'($urandom_range(0, 7))
                                                 : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            a    = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a - (a % 32'(nbytes_of(f3)));
            wd   = $urandom;
            circ = 1'($urandom_range(0, 1));
            step = 32'(4 * $urandom_range(0, 8));
            base = 32'(4 * $urandom_range(0, 64));
            size = 32'(4 * $urandom_range(0, 64));
            nb   = $urandom_range(0, 4);
            ill   = model_illegal(st, f3, a);
            tries = (nb < MAX_RETRY) ? nb : MAX_RETRY;
            e_err = ill || (nb > MAX_RETRY);
            e_lat = ill ? 1 : 3 + 2 * tries;
            e_pul = ill ? 0 : tries + 1;
            e_rd  = (e_err || st) ? 32'd0 : model_load(a, f3);
            e_ptr = model_ptr(a, step, base, size, circ);
            run_op($sformatf("rand%0d", k), st, f3, a, wd, circ, step, base, size, nb,
                   e_err, e_lat, e_rd, e_ptr, e_pul);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
